mem_byte_sequencer: RTL and testbench

- Load/store sequencer between the single-cycle core's data path and the byte-wide (8-bit) data memory, which has combinational read and synchronous write.
- Turns one RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW request into 1, 2 or 4 consecutive byte accesses, little-endian.
- Assembles load data with sign or zero extension and reports completion with a one-cycle done pulse.

---
 rtl/mem_byte_sequencer_if.sv | 26 ++
 rtl/mem_byte_sequencer.sv | 138 +++++++++++++
 tb/tb_mem_byte_sequencer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mem_byte_sequencer_if.sv
// Core-side load/store request bundle for mem_byte_sequencer.
// master = data path issuing requests, slave = the sequencer.
interface mem_byte_sequencer_if #(
   parameter int N    = 10,
   parameter int XLEN = 32
);
   logic            req;
   logic            we;
   logic [2:0]      funct3;
   logic [N-1:0]    addr;
   logic [XLEN-1:0] wdata;
   logic            busy;
   logic            done;
   logic            err;
   logic [XLEN-1:0] rdata;

   modport master (
      output req, we, funct3, addr, wdata,
      input  busy, done, err, rdata
   );

   modport slave (
      input  req, we, funct3, addr, wdata,
      output busy, done, err, rdata
   );
endinterface

// File: rtl/mem_byte_sequencer.sv
// Splits one RISC-V load/store into 1/2/4 little-endian byte accesses on a byte-wide memory.
// Optional macro MISALIGN_CHECK_EN rejects halfword/word requests that are not size-aligned.
module mem_byte_sequencer #(
   parameter int N    = 10,
   parameter int XLEN = 32
) (
   input  logic                clk,
   input  logic                rst,
   mem_byte_sequencer_if.slave core,
   output logic                mem_WE,
   output logic [N-1:0]        mem_A,
   output logic [7:0]          mem_WD,
   input  logic [7:0]          mem_RD
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t          state_q, state_d;
   logic [1:0]      idx_q, idx_d;
   logic            we_q, we_d;
   logic [2:0]      f3_q, f3_d;
   logic [N-1:0]    addr_q, addr_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [XLEN-1:0] buf_q, buf_d;
   logic [XLEN-1:0] rdata_q, rdata_d;
   logic            err_q, err_d;
   logic            misalign;

   function automatic logic [1:0] last_idx(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 2'd0;
         2'b01:   return 2'd1;
         default: return 2'd3;
      endcase
   endfunction

   function automatic logic f3_valid(input logic w, input logic [2:0] f3);
      if (w) return f3 inside {3'b000, 3'b001, 3'b010};
      return f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
   endfunction

   function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] raw, input logic [2:0] f3);
      case (f3)
         3'b000:  return {{(XLEN-8){raw[7]}}, raw[7:0]};
         3'b001:  return {{(XLEN-16){raw[15]}}, raw[15:0]};
         3'b100:  return {{(XLEN-8){1'b0}}, raw[7:0]};
         3'b101:  return {{(XLEN-16){1'b0}}, raw[15:0]};
         default: return raw;
      endcase
   endfunction

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      we_d     = we_q;
      f3_d     = f3_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      buf_d    = buf_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      mem_WE   = 1'b0;
      mem_A    = '0;
      mem_WD   = '0;
`ifdef MISALIGN_CHECK_EN
      misalign = ((core.funct3[1:0] == 2'b01) && core.addr[0]) ||
                 ((core.funct3[1:0] == 2'b10) && (core.addr[1:0] != 2'b00));
`else
      misalign = 1'b0;
`endif

      case (state_q)
         IDLE: begin
            if (core.req) begin
               we_d    = core.we;
               f3_d    = core.funct3;
               addr_d  = core.addr;
               wdata_d = core.wdata;
               idx_d   = 2'd0;
               // Rejected requests skip ACCESS entirely, so memory and rdata stay untouched.
               if (!f3_valid(core.we, core.funct3) || misalign) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  err_d   = 1'b0;
                  state_d = ACCESS;
               end
            end
         end
         ACCESS: begin
            mem_A = addr_q + N'(idx_q);
            if (we_q) begin
               mem_WE = 1'b1;
               mem_WD = wdata_q[{idx_q, 3'b000} +: 8];
            end else begin
               buf_d[{idx_q, 3'b000} +: 8] = mem_RD;
            end
            if (idx_q == last_idx(f3_q)) begin
               state_d = DONE;
               // The final byte goes straight from mem_RD into the extended result.
               if (!we_q) rdata_d = extend(buf_d, f3_q);
            end else begin
               idx_d = idx_q + 2'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= 2'd0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      buf_q   <= buf_d;
   end

   assign core.busy  = (state_q != IDLE);
   assign core.done  = (state_q == DONE);
   assign core.err   = (state_q == DONE) && err_q;
   assign core.rdata = rdata_q;

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// Directed bench for mem_byte_sequencer: vector table of load/store transactions plus
// hand-written sequences for reset mid-store and requests arriving while busy.
module tb_mem_byte_sequencer;
   localparam int N    = 10;
   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            mem_WE;
   logic [N-1:0]    mem_A;
   logic [7:0]      mem_WD;
   logic [7:0]      mem_RD;
   logic [7:0]      mem [0:(1<<N)-1];

   int checks = 0;
   int errors = 0;

   mem_byte_sequencer_if #(.N(N), .XLEN(XLEN)) bus ();

   mem_byte_sequencer #(.N(N), .XLEN(XLEN)) dut (
      .clk    (clk),
      .rst    (rst),
      .core   (bus.slave),
      .mem_WE (mem_WE),
      .mem_A  (mem_A),
      .mem_WD (mem_WD),
      .mem_RD (mem_RD)
   );

   always #5 clk = ~clk;

   assign mem_RD = mem[mem_A];
   always @(posedge clk) if (mem_WE) mem[mem_A] <= mem_WD;

   typedef struct {
      logic         we;
      logic [2:0]   f3;
      logic [N-1:0] addr;
      logic [31:0]  wd;
      int           lat;
      logic         err;
      logic [31:0]  rd;
      int           nwr;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic run_op(input int id, input vec_t v);
      int   lat, nwr, bcnt;
      logic got, err_s;
      logic [31:0] rd_s;
      @(negedge clk);
      bus.req = 1'b1; bus.we = v.we; bus.funct3 = v.f3; bus.addr = v.addr; bus.wdata = v.wd;
      @(posedge clk);
      #1 bus.req = 1'b0;
      lat = 0; nwr = 0; bcnt = 0; got = 1'b0; err_s = 1'b0; rd_s = '0;
      for (int c = 1; c <= 10 && !got; c++) begin
         @(negedge clk);
         if (mem_WE) nwr++;
         if (bus.busy === 1'b1) bcnt++;
         if (bus.done === 1'b1) begin
            got = 1'b1; lat = c; err_s = bus.err; rd_s = bus.rdata;
         end
      end
      chk($sformatf("v%0d latency", id), lat, v.lat);
      chk($sformatf("v%0d busy_cycles", id), bcnt, v.lat);
      chk($sformatf("v%0d err", id), {31'd0, err_s}, {31'd0, v.err});
      chk($sformatf("v%0d rdata", id), rd_s, v.rd);
      chk($sformatf("v%0d writes", id), nwr, v.nwr);
      @(negedge clk);
      chk($sformatf("v%0d idle_after", id), {30'd0, bus.done, bus.busy}, 32'd0);
   endtask

   initial begin
      int dcnt, wecnt, done_c;
      for (int i = 0; i < (1 << N); i++) mem[i] = 8'h00;
      mem[10'h010] = 8'h80;
      mem[10'h022] = 8'h55;
      mem[10'h023] = 8'h66;
      bus.req = 1'b0; bus.we = 1'b0; bus.funct3 = 3'b000; bus.addr = '0; bus.wdata = '0;

      //           we    f3      addr     wdata         lat err rdata         nwr
      vecs[0]  = '{1'b1, 3'b010, 10'h004, 32'h12345678, 5, 1'b0, 32'h00000000, 4};
      vecs[1]  = '{1'b0, 3'b010, 10'h004, 32'h0,        5, 1'b0, 32'h12345678, 0};
      vecs[2]  = '{1'b0, 3'b001, 10'h006, 32'h0,        3, 1'b0, 32'h00001234, 0};
      vecs[3]  = '{1'b0, 3'b000, 10'h010, 32'h0,        2, 1'b0, 32'hFFFFFF80, 0};
      vecs[4]  = '{1'b0, 3'b100, 10'h010, 32'h0,        2, 1'b0, 32'h00000080, 0};
      vecs[5]  = '{1'b1, 3'b000, 10'h011, 32'h7777779A, 2, 1'b0, 32'h00000080, 1};
      vecs[6]  = '{1'b0, 3'b001, 10'h010, 32'h0,        3, 1'b0, 32'hFFFF9A80, 0};
      vecs[7]  = '{1'b0, 3'b101, 10'h010, 32'h0,        3, 1'b0, 32'h00009A80, 0};
`ifdef MISALIGN_CHECK_EN
      vecs[8]  = '{1'b1, 3'b001, 10'h3FF, 32'h0000ABCD, 1, 1'b1, 32'h00009A80, 0};
`else
      vecs[8]  = '{1'b1, 3'b001, 10'h3FF, 32'h0000ABCD, 3, 1'b0, 32'h00009A80, 2};
`endif
      vecs[9]  = '{1'b0, 3'b011, 10'h000, 32'h0,        1, 1'b1, 32'h00009A80, 0};
      vecs[10] = '{1'b1, 3'b100, 10'h030, 32'hDEADBEEF, 1, 1'b1, 32'h00009A80, 0};
      vecs[11] = '{1'b0, 3'b111, 10'h004, 32'h0,        1, 1'b1, 32'h00009A80, 0};
      vecs[12] = '{1'b0, 3'b110, 10'h004, 32'h0,        1, 1'b1, 32'h00009A80, 0};
      vecs[13] = '{1'b1, 3'b111, 10'h030, 32'hDEADBEEF, 1, 1'b1, 32'h00009A80, 0};

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset busy_done_err_we", {28'd0, bus.busy, bus.done, bus.err, mem_WE}, 32'd0);
      chk("reset rdata", bus.rdata, 32'd0);
      chk("reset mem_A", {22'd0, mem_A}, 32'd0);
      chk("reset mem_WD", {24'd0, mem_WD}, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 14; i++) run_op(i, vecs[i]);

      chk("sw mem4..7", {mem[7], mem[6], mem[5], mem[4]}, 32'h12345678);
      chk("sb mem11", {24'd0, mem[10'h011]}, 32'h9A);
      chk("reject no write mem30", {mem[10'h033], mem[10'h032], mem[10'h031], mem[10'h030]}, 32'd0);
`ifdef MISALIGN_CHECK_EN
      chk("sh wrap mem3FF", {24'd0, mem[10'h3FF]}, 32'h00);
      chk("sh wrap mem000", {24'd0, mem[10'h000]}, 32'h00);
`else
      chk("sh wrap mem3FF", {24'd0, mem[10'h3FF]}, 32'hCD);
      chk("sh wrap mem000", {24'd0, mem[10'h000]}, 32'hAB);
`endif

      // Reset after two ACCESS cycles of a word store.
      @(negedge clk);
      bus.req = 1'b1; bus.we = 1'b1; bus.funct3 = 3'b010; bus.addr = 10'h020; bus.wdata = 32'hAABBCCDD;
      @(posedge clk);
      #1 bus.req = 1'b0;
      @(negedge clk);
      chk("rstmid T1 we_addr", {21'd0, mem_WE, mem_A}, {21'd0, 1'b1, 10'h020});
      @(negedge clk);
      chk("rstmid T2 we_addr", {21'd0, mem_WE, mem_A}, {21'd0, 1'b1, 10'h021});
      chk("rstmid T2 done", {31'd0, bus.done}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("rstmid outs", {28'd0, bus.busy, bus.done, bus.err, mem_WE}, 32'd0);
      chk("rstmid mem_A_WD", {14'd0, mem_A, mem_WD}, 32'd0);
      chk("rstmid rdata", bus.rdata, 32'd0);
      rst = 1'b0;
      bus.req = 1'b1; bus.we = 1'b0; bus.funct3 = 3'b100; bus.addr = 10'h021;
      @(posedge clk);
      #1 bus.req = 1'b0;
      @(negedge clk);
      chk("rstmid new req busy", {31'd0, bus.busy}, 32'd1);
      @(negedge clk);
      chk("rstmid new req done", {31'd0, bus.done}, 32'd1);
      chk("rstmid new req rdata", bus.rdata, 32'h000000CC);
      chk("rstmid mem20..23", {mem[10'h023], mem[10'h022], mem[10'h021], mem[10'h020]}, 32'h6655CCDD);

      // Requests while busy and during done must be dropped.
      @(negedge clk);
      bus.req = 1'b1; bus.we = 1'b0; bus.funct3 = 3'b010; bus.addr = 10'h004;
      @(posedge clk);
      #1 bus.req = 1'b0;
      dcnt = 0; wecnt = 0; done_c = 0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin dcnt++; if (done_c == 0) done_c = c; end
         if (mem_WE) wecnt++;
         if (c == 2 || c == 5) begin
            bus.req = 1'b1; bus.we = 1'b1; bus.funct3 = 3'b010; bus.addr = 10'h100; bus.wdata = 32'hFFFFFFFF;
         end else begin
            bus.req = 1'b0;
         end
      end
      chk("busyreq done count", dcnt, 1);
      chk("busyreq done cycle", done_c, 5);
      chk("busyreq no writes", wecnt, 0);
      chk("busyreq mem100", {mem[10'h103], mem[10'h102], mem[10'h101], mem[10'h100]}, 32'd0);
      chk("busyreq rdata", bus.rdata, 32'h12345678);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
